// File: rtl/rx_byte_stack_queue.sv
// Circular capture buffer between the UART receiver and the LED display.
// Each pop can take the oldest word (queue) or the newest word (stack).
module rx_byte_stack_queue #(
  parameter int DW        = 8,
  parameter int LGDEPTH   = 3,
  parameter int OVERWRITE = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr,
  input  logic [DW-1:0]      i_data,
  input  logic               i_pop,
  input  logic               i_mode,
  input  logic               i_clr,
  output logic [DW-1:0]      o_disp,
  output logic               o_disp_valid,
  output logic [LGDEPTH:0]   o_count,
  output logic               o_empty_n,
  output logic               o_full,
  output logic               o_ovf,
  output logic               o_unf
);

  localparam int DEPTH = 1 << LGDEPTH;
  localparam logic [LGDEPTH:0]   FULL_COUNT = {1'b1, {LGDEPTH{1'b0}}};
  localparam logic [LGDEPTH-1:0] PTR_ONE    = LGDEPTH'(1);
  localparam logic [LGDEPTH:0]   CNT_ONE    = (LGDEPTH + 1)'(1);

  logic [DW-1:0]      mem [DEPTH];
  logic [LGDEPTH-1:0] rd_ptr, wr_ptr;
  logic [LGDEPTH:0]   count;
  logic [DW-1:0]      disp;
  logic               disp_valid, ovf, unf;

  logic               is_full, is_empty;
  logic [LGDEPTH-1:0] newest_ptr, pop_addr;
  logic [DW-1:0]      pop_word;

  logic               mem_we;
  logic [LGDEPTH-1:0] mem_addr;
  logic [LGDEPTH-1:0] rd_ptr_nxt, wr_ptr_nxt;
  logic [LGDEPTH:0]   count_nxt;
  logic [DW-1:0]      disp_nxt;
  logic               disp_valid_nxt, ovf_nxt, unf_nxt;

  assign is_full    = (count == FULL_COUNT);
  assign is_empty   = (count == '0);
  assign newest_ptr = wr_ptr - PTR_ONE;
  assign pop_addr   = i_mode ? newest_ptr : rd_ptr;
  assign pop_word   = mem[pop_addr];

  // A stack pop with a same-cycle write reuses the popped slot, so wr_ptr holds.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = wr_ptr;
    rd_ptr_nxt     = rd_ptr;
    wr_ptr_nxt     = wr_ptr;
    count_nxt      = count;
    disp_nxt       = disp;
    disp_valid_nxt = disp_valid;
    ovf_nxt        = ovf;
    unf_nxt        = 1'b0;

    if (i_clr) begin
      rd_ptr_nxt     = '0;
      wr_ptr_nxt     = '0;
      count_nxt      = '0;
      disp_nxt       = '0;
      disp_valid_nxt = 1'b0;
      ovf_nxt        = 1'b0;
    end else if (i_pop && !is_empty) begin
      disp_nxt       = pop_word;
      disp_valid_nxt = 1'b1;
      if (i_wr) begin
        mem_we = 1'b1;
        if (i_mode) begin
          mem_addr = newest_ptr;
        end else begin
          mem_addr   = wr_ptr;
          rd_ptr_nxt = rd_ptr + PTR_ONE;
          wr_ptr_nxt = wr_ptr + PTR_ONE;
        end
      end else begin
        count_nxt = count - CNT_ONE;
        if (i_mode) begin
          wr_ptr_nxt = newest_ptr;
        end else begin
          rd_ptr_nxt = rd_ptr + PTR_ONE;
        end
      end
    end else begin
      if (i_pop) begin
        disp_nxt       = '0;
        disp_valid_nxt = 1'b0;
        unf_nxt        = 1'b1;
      end
      if (i_wr) begin
        if (!is_full) begin
          mem_we     = 1'b1;
          wr_ptr_nxt = wr_ptr + PTR_ONE;
          count_nxt  = count + CNT_ONE;
        end else begin
          ovf_nxt = 1'b1;
          if (OVERWRITE != 0) begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + PTR_ONE;
            rd_ptr_nxt = rd_ptr + PTR_ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_addr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      disp       <= '0;
      disp_valid <= 1'b0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      count      <= count_nxt;
      disp       <= disp_nxt;
      disp_valid <= disp_valid_nxt;
      ovf        <= ovf_nxt;
      unf        <= unf_nxt;
    end
  end

  assign o_disp       = disp;
  assign o_disp_valid = disp_valid;
  assign o_count      = count;
  assign o_empty_n    = !is_empty;
  assign o_full       = is_full;
  assign o_ovf        = ovf;
  assign o_unf        = unf;

endmodule

// File: tb/tb_rx_byte_stack_queue.sv
// Self-checking bench: drop-policy and overwrite-policy instances share one
// directed stimulus and are compared every cycle against a list-based model.
`timescale 1ns/1ps
module tb_rx_byte_stack_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0, pop = 1'b0, mode = 1'b0, clr = 1'b0;
  logic [7:0] data = 8'h00;

  logic [1:0][7:0] disp;
  logic [1:0][3:0] count;
  logic [1:0]      disp_valid, empty_n, full, ovf, unf;

  int  checks = 0;
  int  errors = 0;
  bit  checking = 1'b0;

  always #5 clk = ~clk;

  rx_byte_stack_queue #(.DW(8), .LGDEPTH(3), .OVERWRITE(0)) dut_drop (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_data(data), .i_pop(pop),
    .i_mode(mode), .i_clr(clr), .o_disp(disp[0]), .o_disp_valid(disp_valid[0]),
    .o_count(count[0]), .o_empty_n(empty_n[0]), .o_full(full[0]),
    .o_ovf(ovf[0]), .o_unf(unf[0]));

  rx_byte_stack_queue #(.DW(8), .LGDEPTH(3), .OVERWRITE(1)) dut_ovwr (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_data(data), .i_pop(pop),
    .i_mode(mode), .i_clr(clr), .o_disp(disp[1]), .o_disp_valid(disp_valid[1]),
    .o_count(count[1]), .o_empty_n(empty_n[1]), .o_full(full[1]),
    .o_ovf(ovf[1]), .o_unf(unf[1]));

  // Model: m_list[p][0] is the oldest stored word, m_list[p][m_n[p]-1] the newest.
  logic [7:0] m_list [2][8];
  int         m_n [2];
  logic [7:0] m_disp [2];
  bit         m_valid [2], m_ovf [2], m_unf [2];

  task automatic drop_oldest(input int p);
    for (int i = 0; i < 7; i++) m_list[p][i] = m_list[p][i+1];
    m_n[p] = m_n[p] - 1;
  endtask

  task automatic push_newest(input int p, input logic [7:0] w);
    m_list[p][m_n[p]] = w;
    m_n[p] = m_n[p] + 1;
  endtask

  task automatic model_step(input int p);
    m_unf[p] = 1'b0;
    if (clr) begin
      m_n[p] = 0; m_disp[p] = 8'h00; m_valid[p] = 1'b0; m_ovf[p] = 1'b0;
    end else if (pop && m_n[p] > 0) begin
      m_valid[p] = 1'b1;
      if (mode) begin
        m_disp[p] = m_list[p][m_n[p]-1];
        m_n[p] = m_n[p] - 1;
      end else begin
        m_disp[p] = m_list[p][0];
        drop_oldest(p);
      end
      if (wr) push_newest(p, data);
    end else begin
      if (pop) begin
        m_disp[p] = 8'h00; m_valid[p] = 1'b0; m_unf[p] = 1'b1;
      end
      if (wr) begin
        if (m_n[p] < 8) begin
          push_newest(p, data);
        end else begin
          m_ovf[p] = 1'b1;
          if (p == 1) begin
            drop_oldest(p);
            push_newest(p, data);
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int p = 0; p < 2; p++) begin
        if (!rst_n) begin
          m_n[p] = 0; m_disp[p] = 8'h00; m_valid[p] = 1'b0;
          m_ovf[p] = 1'b0; m_unf[p] = 1'b0;
        end else begin
          model_step(p);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int p = 0; p < 2; p++) begin
          checkOutput($sformatf("model_disp[%0d]", p), 32'(disp[p]), 32'(m_disp[p]));
          checkOutput($sformatf("model_valid[%0d]", p), 32'(disp_valid[p]), 32'(m_valid[p]));
          checkOutput($sformatf("model_count[%0d]", p), 32'(count[p]), 32'(m_n[p]));
          checkOutput($sformatf("model_empty_n[%0d]", p), 32'(empty_n[p]), 32'(m_n[p] != 0));
          checkOutput($sformatf("model_full[%0d]", p), 32'(full[p]), 32'(m_n[p] == 8));
          checkOutput($sformatf("model_ovf[%0d]", p), 32'(ovf[p]), 32'(m_ovf[p]));
          checkOutput($sformatf("model_unf[%0d]", p), 32'(unf[p]), 32'(m_unf[p]));
        end
      end
    end
  end

  // Drives one cycle of inputs; returns 1 ns after the edge that consumed them.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic p,
                               input logic m, input logic c);
    wr = w; data = d; pop = p; mode = m; clr = c;
    @(posedge clk);
    #1;
    wr = 1'b0; data = 8'h00; pop = 1'b0; mode = 1'b0; clr = 1'b0;
  endtask

  task automatic writeWord(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popWord(input logic m);
    applyStimulus(1'b0, 8'h00, 1'b1, m, 1'b0);
  endtask

  task automatic flush();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  logic [7:0] exp_q [3] = '{8'h11, 8'h22, 8'h33};
  logic [7:0] exp_s [3] = '{8'h33, 8'h22, 8'h11};

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    checkOutput("reset_count", 32'(count[0]), 32'd0);
    checkOutput("reset_empty_n", 32'(empty_n[0]), 32'd0);
    checkOutput("reset_disp", 32'(disp[1]), 32'd0);
    rst_n = 1'b1;

    // Queue order.
    writeWord(8'h11); writeWord(8'h22); writeWord(8'h33);
    checkOutput("fill3_count", 32'(count[0]), 32'd3);
    for (int i = 0; i < 3; i++) begin
      popWord(1'b0);
      checkOutput($sformatf("queue_pop%0d", i), 32'(disp[0]), 32'(exp_q[i]));
    end
    checkOutput("queue_end_count", 32'(count[0]), 32'd0);
    checkOutput("queue_end_empty_n", 32'(empty_n[0]), 32'd0);

    // Stack order, then underflow.
    writeWord(8'h11); writeWord(8'h22); writeWord(8'h33);
    for (int i = 0; i < 3; i++) begin
      popWord(1'b1);
      checkOutput($sformatf("stack_pop%0d", i), 32'(disp[0]), 32'(exp_s[i]));
    end
    popWord(1'b1);
    checkOutput("unf_disp", 32'(disp[0]), 32'd0);
    checkOutput("unf_valid", 32'(disp_valid[0]), 32'd0);
    checkOutput("unf_pulse", 32'(unf[0]), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("unf_drop", 32'(unf[0]), 32'd0);

    // Nine writes into depth 8 under both policies.
    for (int i = 1; i <= 9; i++) begin
      writeWord(8'(i));
      if (i == 8) checkOutput("full_after8", 32'(full[0]), 32'd1);
      if (i == 8) checkOutput("no_ovf_after8", 32'(ovf[0]), 32'd0);
    end
    checkOutput("drop_ovf", 32'(ovf[0]), 32'd1);
    checkOutput("ovwr_ovf", 32'(ovf[1]), 32'd1);
    checkOutput("ovwr_count", 32'(count[1]), 32'd8);
    for (int i = 0; i < 8; i++) begin
      popWord(1'b0);
      checkOutput($sformatf("drop_pop%0d", i), 32'(disp[0]), 32'(i + 1));
      checkOutput($sformatf("ovwr_pop%0d", i), 32'(disp[1]), 32'(i + 2));
    end
    checkOutput("ovf_sticky", 32'(ovf[0]), 32'd1);
    flush();
    checkOutput("flush_ovf", 32'(ovf[0]), 32'd0);

    // Full buffer, write with same-cycle pop; then clear beats a write.
    for (int i = 1; i <= 8; i++) writeWord(8'(i));
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    checkOutput("wrpop_full_disp", 32'(disp[0]), 32'h01);
    checkOutput("wrpop_full_count", 32'(count[0]), 32'd8);
    checkOutput("wrpop_full_ovf", 32'(ovf[0]), 32'd0);
    checkOutput("wrpop_full_ovf_ow", 32'(ovf[1]), 32'd0);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_count", 32'(count[0]), 32'd0);
    checkOutput("clr_ovf", 32'(ovf[0]), 32'd0);
    checkOutput("clr_disp", 32'(disp[0]), 32'd0);

    // Mixed modes on one store.
    writeWord(8'hA1); writeWord(8'hA2); writeWord(8'hA3); writeWord(8'hA4);
    popWord(1'b1);
    checkOutput("mix_stack", 32'(disp[0]), 32'hA4);
    popWord(1'b0);
    checkOutput("mix_queue", 32'(disp[0]), 32'hA1);
    applyStimulus(1'b1, 8'hB1, 1'b1, 1'b1, 1'b0);
    checkOutput("mix_wrpop_stack", 32'(disp[0]), 32'hA3);
    applyStimulus(1'b1, 8'hB2, 1'b1, 1'b0, 1'b0);
    checkOutput("mix_wrpop_queue", 32'(disp[0]), 32'hA2);
    popWord(1'b1);
    checkOutput("mix_tail0", 32'(disp[0]), 32'hB2);
    popWord(1'b1);
    checkOutput("mix_tail1", 32'(disp[0]), 32'hB1);

    // Pop on empty with a same-cycle write: underflow, word still stored.
    applyStimulus(1'b1, 8'hC1, 1'b1, 1'b0, 1'b0);
    checkOutput("empty_wrpop_unf", 32'(unf[0]), 32'd1);
    checkOutput("empty_wrpop_count", 32'(count[0]), 32'd1);
    popWord(1'b0);
    checkOutput("empty_wrpop_word", 32'(disp[0]), 32'hC1);

    // Asynchronous reset in the middle of a clock period.
    writeWord(8'h5A); writeWord(8'h6B);
    popWord(1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_count", 32'(count[0]), 32'd0);
    checkOutput("async_disp", 32'(disp[0]), 32'd0);
    checkOutput("async_valid", 32'(disp_valid[0]), 32'd0);
    checkOutput("async_empty_n", 32'(empty_n[1]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    popWord(1'b0);
    checkOutput("post_reset_unf", 32'(unf[0]), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
